// File: rtl/fifo_128to16_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_128to16_unpacker
// Purpose  : Read-side width downsizer. Pulls IN_WIDTH-bit words from a
//            non-FWFT FIFO read port and emits them as an OUT_WIDTH-bit
//            valid/ready stream (IN_WIDTH/OUT_WIDTH beats per word). It also
//            counts beats per line, flags the last beat of each line, and
//            counts cycles starved of data in the middle of a line.
// Ports    : clk           - FIFO read clock and stream clock
//            tb_rst        - asynchronous active-high reset
//            fifo_rd_en    - FIFO read strobe (combinational)
//            fifo_rd_data  - FIFO word, valid the cycle after fifo_rd_en
//            fifo_rd_empty - FIFO empty flag
//            m_data        - output beat
//            m_valid       - output beat valid
//            m_ready       - downstream accept
//            m_last        - last beat of the current line
//            underrun_cnt  - saturating count of mid-line starved cycles
// Revision : 1.0 - initial release
// ============================================================================
module fifo_128to16_unpacker #(
   parameter int IN_WIDTH   = 128,
   parameter int OUT_WIDTH  = 16,
   parameter int LSB_FIRST  = 1,
   parameter int LINE_BEATS = 1024,
   parameter int CNT_W      = 10
) (
   input  logic                 clk,
   input  logic                 tb_rst,
   output logic                 fifo_rd_en,
   input  logic [IN_WIDTH-1:0]  fifo_rd_data,
   input  logic                 fifo_rd_empty,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic [7:0]           underrun_cnt
);

   localparam int                c_lanes     = IN_WIDTH / OUT_WIDTH;
   localparam int                c_lane_w    = (c_lanes > 1) ? $clog2(c_lanes) : 1;
   localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(c_lanes - 1);
   localparam logic [CNT_W-1:0]  c_last_beat = CNT_W'(LINE_BEATS - 1);

   // Shift buffer (word being emitted), next buffer, and read-in-flight flag
   logic [IN_WIDTH-1:0]  r_sb_data;
   logic                 r_sb_v;
   logic [c_lane_w-1:0]  r_lane;
   logic [IN_WIDTH-1:0]  r_nb_data;
   logic                 r_nb_v;
   logic                 r_inflight;
   logic [CNT_W-1:0]     r_cnt;
   logic [7:0]           r_underrun;

   logic                 w_hs;
   logic                 w_release;
   logic                 w_sb_free;
   logic [1:0]           w_occ;
   logic [OUT_WIDTH-1:0] w_lanes [c_lanes];

   assign w_hs      = r_sb_v && m_ready;
   assign w_release = w_hs && (r_lane == c_last_lane);
   assign w_sb_free = !r_sb_v || w_release;

   // Words held or in flight after this edge; a shift buffer that hands off
   // its last lane this cycle already counts as free so reads never bubble.
   assign w_occ = {1'b0, r_sb_v & ~w_release} + {1'b0, r_nb_v} + {1'b0, r_inflight};

   assign fifo_rd_en = !tb_rst && !fifo_rd_empty && (w_occ < 2'd2);

   // Lane k is the k-th beat sent, so the beat order follows LSB_FIRST
   for (genvar i = 0; i < c_lanes; i++) begin : g_lane
      if (LSB_FIRST != 0) begin : g_lsb
         assign w_lanes[i] = r_sb_data[i*OUT_WIDTH +: OUT_WIDTH];
      end else begin : g_msb
         assign w_lanes[i] = r_sb_data[(c_lanes-1-i)*OUT_WIDTH +: OUT_WIDTH];
      end
   end

   assign m_data       = w_lanes[r_lane];
   assign m_valid      = r_sb_v;
   assign m_last       = r_sb_v && (r_cnt == c_last_beat);
   assign underrun_cnt = r_underrun;

   // Word buffers: NB advances into SB on the edge SB releases its last lane;
   // a returning FIFO word fills whichever slot is free after that move.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         r_sb_data  <= '0;
         r_sb_v     <= 1'b0;
         r_nb_data  <= '0;
         r_nb_v     <= 1'b0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= fifo_rd_en;
         if (w_sb_free) begin
            if (r_nb_v) begin
               r_sb_data <= r_nb_data;
               r_sb_v    <= 1'b1;
               r_nb_v    <= r_inflight;
               if (r_inflight) begin
                  r_nb_data <= fifo_rd_data;
               end
            end else if (r_inflight) begin
               r_sb_data <= fifo_rd_data;
               r_sb_v    <= 1'b1;
            end else begin
               r_sb_v    <= 1'b0;
            end
         end else if (r_inflight) begin
            r_nb_data <= fifo_rd_data;
            r_nb_v    <= 1'b1;
         end
      end
   end

   // Lane index, beat-in-line counter and starvation counter
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         r_lane     <= '0;
         r_cnt      <= '0;
         r_underrun <= '0;
      end else begin
         if (w_hs) begin
            r_lane <= w_release ? '0 : r_lane + 1'b1;
            r_cnt  <= (r_cnt == c_last_beat) ? '0 : r_cnt + 1'b1;
         end
         // Idle between lines (count at zero) is not starvation
         if ((r_cnt != '0) && !r_sb_v && (r_underrun != 8'hFF)) begin
            r_underrun <= r_underrun + 8'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_128to16_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_128to16_unpacker
// Purpose  : Self-checking bench for fifo_128to16_unpacker. A FIFO model
//            feeds words; every word pushed is expanded into its expected
//            beats (lane k = bits [16k+15:16k]) and the DUT stream is checked
//            against that queue, the line position, and the word-holding
//            limit on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_128to16_unpacker;

   localparam int LINE = 1024;

   logic         clk = 1'b0;
   logic         tb_rst = 1'b0;
   logic         fifo_rd_en;
   logic [127:0] fifo_rd_data;
   logic         fifo_rd_empty;
   logic [15:0]  m_data;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         m_last;
   logic [7:0]   underrun_cnt;

   fifo_128to16_unpacker #(
      .IN_WIDTH   (128),
      .OUT_WIDTH  (16),
      .LSB_FIRST  (1),
      .LINE_BEATS (LINE),
      .CNT_W      (10)
   ) dut (
      .clk           (clk),
      .tb_rst        (tb_rst),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_empty (fifo_rd_empty),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_last        (m_last),
      .underrun_cnt  (underrun_cnt)
   );

   always #5 clk = ~clk;

   // FIFO model: data appears the cycle after the read strobe; reset empties it
   logic [127:0] mem [0:1023];
   int           wr_ptr = 0;
   int           rd_ptr = 0;

   assign fifo_rd_empty = (rd_ptr == wr_ptr);

   always @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         rd_ptr       <= wr_ptr;
         fifo_rd_data <= '0;
      end else if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_ptr % 1024];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   // Reference model and bookkeeping
   int           vectors = 0;
   int           miscompares = 0;
   logic [15:0]  exp_q [$];
   logic [127:0] pend_q [$];
   int           model_cnt, beats_done, reads_issued, cyc;
   int           first_rd, first_valid, last_hs, gaps, last_cnt;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic [127:0] w);
      pend_q.push_back(w);
   endtask

   // One clock cycle: apply pending pushes and m_ready at the falling edge,
   // then check the settled outputs and account for the coming rising edge.
   task automatic step(input logic rdy);
      logic [127:0] w;
      logic         hs;
      int           held;
      @(negedge clk);
      while (pend_q.size() > 0) begin
         w = pend_q.pop_front();
         mem[wr_ptr % 1024] = w;
         wr_ptr++;
         for (int k = 0; k < 8; k++) exp_q.push_back(w[16*k +: 16]);
      end
      m_ready = rdy;
      #1;
      cyc++;
      if (m_valid) begin
         if (exp_q.size() == 0) begin
            chk("beat_without_data", m_valid, 1'b0);
         end else begin
            chk("m_data", m_data, exp_q[0]);
            chk("m_last", m_last, (model_cnt == LINE - 1));
         end
         if (first_valid < 0) first_valid = cyc;
      end else begin
         chk("m_last_idle", m_last, 1'b0);
         if (first_valid >= 0 && exp_q.size() > 0) gaps++;
      end
      hs = m_valid && m_ready;
      if (fifo_rd_en) begin
         reads_issued++;
         if (first_rd < 0) first_rd = cyc;
      end
      if (hs) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (m_last) last_cnt++;
         model_cnt  = (model_cnt + 1) % LINE;
         beats_done++;
         last_hs    = cyc;
      end
      held = reads_issued - beats_done / 8;
      chk("held_le_2", (held <= 2), 1'b1);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      tb_rst  = 1'b1;
      m_ready = 1'b0;
      exp_q.delete();
      pend_q.delete();
      model_cnt = 0; beats_done = 0; reads_issued = 0;
      first_rd = -1; first_valid = -1; last_hs = -1; gaps = 0; last_cnt = 0;
      repeat (n) @(negedge clk);
      tb_rst = 1'b0;
   endtask

   initial begin
      logic [127:0] w;
      cyc = 0;

      // T1: reset held 200 ns, read strobe suppressed even with data present
      #1 tb_rst = 1'b1;
      #2;
      mem[wr_ptr % 1024] = 128'h1234;
      wr_ptr++;
      #1;
      chk("t1_rd_en_in_reset", fifo_rd_en, 1'b0);
      chk("t1_m_valid", m_valid, 1'b0);
      #196;
      chk("t1_m_valid_200ns", m_valid, 1'b0);
      chk("t1_m_last", m_last, 1'b0);
      chk("t1_rd_en", fifo_rd_en, 1'b0);
      chk("t1_underrun", underrun_cnt, 8'd0);
      chk("t1_m_data", m_data, 16'd0);
      do_reset(2);

      // T2: single word, 8 beats on consecutive cycles
      w = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
      push(w);
      for (int i = 0; i < 30 && beats_done < 8; i++) step(1'b1);
      repeat (5) step(1'b1);
      chk("t2_beats", beats_done, 8);
      chk("t2_single_read", reads_issued, 1);
      chk("t2_latency", first_valid - first_rd, 2);
      chk("t2_consecutive", last_hs - first_valid, 7);
      chk("t2_queue_empty", exp_q.size(), 0);

      // T3: 256 incrementing words, always ready
      do_reset(2);
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'(i*8 + k);
         push(w);
      end
      for (int i = 0; i < 2200 && beats_done < 2048; i++) step(1'b1);
      repeat (3) step(1'b1);
      chk("t3_beats", beats_done, 2048);
      chk("t3_no_gaps", gaps, 0);
      chk("t3_last_count", last_cnt, 2);
      chk("t3_underrun", underrun_cnt, 8'd0);
      chk("t3_queue_empty", exp_q.size(), 0);

      // T4: random words, ready toggling randomly
      do_reset(2);
      for (int i = 0; i < 256; i++) push({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 8000 && beats_done < 2048; i++) step(1'($urandom_range(0, 1)));
      repeat (3) step(1'b1);
      chk("t4_beats", beats_done, 2048);
      chk("t4_last_count", last_cnt, 2);
      chk("t4_underrun", underrun_cnt, 8'd0);
      chk("t4_queue_empty", exp_q.size(), 0);

      // T5: 3 words, FIFO starved, refill 19 cycles after valid drops
      do_reset(2);
      for (int i = 0; i < 3; i++) push({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 100; i++) begin
         step(1'b1);
         if (!m_valid && beats_done == 24) break;
      end
      chk("t5_drop_after_24", beats_done, 24);
      chk("t5_valid_low", m_valid, 1'b0);
      repeat (18) step(1'b1);
      for (int i = 0; i < 2; i++) push({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 60 && beats_done < 40; i++) step(1'b1);
      chk("t5_beats", beats_done, 40);
      chk("t5_underrun", underrun_cnt, 8'd21);

      // T6: asynchronous reset mid-line, then a fresh line from count 0
      do_reset(2);
      for (int i = 0; i < 128; i++) push({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 700 && beats_done < 500; i++) step(1'b1);
      chk("t6_pre_beats", beats_done, 500);
      @(posedge clk);
      #2 tb_rst = 1'b1;
      #1;
      chk("t6_m_valid_clear", m_valid, 1'b0);
      chk("t6_m_last_clear", m_last, 1'b0);
      chk("t6_rd_en_clear", fifo_rd_en, 1'b0);
      chk("t6_underrun_clear", underrun_cnt, 8'd0);
      do_reset(3);
      for (int i = 0; i < 130; i++) push({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 1300 && beats_done < 1040; i++) step(1'b1);
      repeat (3) step(1'b1);
      chk("t6_beats", beats_done, 1040);
      chk("t6_last_count", last_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
